// File: rtl/sync_fifo_rd_ctrl.sv
// Purpose: read-side controller for a synchronous FIFO with a registered output stage and a sticky overrun flag.
// Latency: data appears on m_data/m_valid one cycle after wr_ptr advances past rd_ptr.
// Backpressure: m_valid && !m_ready holds the output register and rd_ptr; flush discards all unread data.
module sync_fifo_rd_ctrl #(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic [ADDR_WIDTH:0]   wr_ptr,
    output logic [ADDR_WIDTH:0]   rd_ptr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  mem_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overrun
);

    localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] LP_ONE   = (ADDR_WIDTH+1)'(1);

    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic                  r_m_valid;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic                  r_overrun;

    logic [ADDR_WIDTH:0]   w_mem_count;
    logic                  w_mem_empty;
    logic                  w_load;

    // Pointer difference relies on the wrap bit, so it is taken modulo 2^(ADDR_WIDTH+1).
    assign w_mem_count = wr_ptr - r_rd_ptr;
    assign w_mem_empty = (wr_ptr == r_rd_ptr);
    assign w_load      = !w_mem_empty && (!r_m_valid || m_ready) && !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr  <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_overrun <= 1'b0;
        end else if (flush) begin
            r_rd_ptr  <= wr_ptr;
            r_m_valid <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_load) begin
                r_m_data  <= rd_data;
                r_m_valid <= 1'b1;
                r_rd_ptr  <= r_rd_ptr + LP_ONE;
            end else if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
            end
            // Sticky until flush; the pointer gap itself is left alone.
            if (w_mem_count > LP_DEPTH) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign rd_ptr    = r_rd_ptr;
    assign rd_addr   = r_rd_ptr[ADDR_WIDTH-1:0];
    assign m_valid   = r_m_valid;
    assign m_data    = r_m_data;
    assign mem_empty = w_mem_empty;
    assign level     = w_mem_count + {{ADDR_WIDTH{1'b0}}, r_m_valid};
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_sync_fifo_rd_ctrl.sv
// Bench for sync_fifo_rd_ctrl: memory array, write-pointer driver, arithmetic reference model and
// an in-order scoreboard of written values.
module tb_sync_fifo_rd_ctrl;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 8;

    logic          clk;
    logic          reset_n;
    logic          flush;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          mem_empty;
    logic [AW:0]   level;
    logic          overrun;

    logic [DW-1:0] mem [DEPTH];
    assign rd_data = mem[rd_addr];

    sync_fifo_rd_ctrl #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .mem_empty (mem_empty),
        .level     (level),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: output register contents, read count (mod 32) and overrun flag.
    logic          mv;
    logic [DW-1:0] md;
    int            mrd;
    logic          movr;
    logic [DW-1:0] sb[$];
    bit            sb_en;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int mcount();
        return (int'(wr_ptr) - mrd) & 31;
    endfunction

    task automatic check_all();
        chk("rd_ptr",    32'(rd_ptr),    32'(mrd));
        chk("rd_addr",   32'(rd_addr),   32'(mrd % DEPTH));
        chk("m_valid",   32'(m_valid),   32'(mv));
        chk("m_data",    32'(m_data),    32'(md));
        chk("mem_empty", 32'(mem_empty), 32'(mcount() == 0));
        chk("level",     32'(level),     32'((mcount() + int'(mv)) & 31));
        chk("overrun",   32'(overrun),   32'(movr));
    endtask

    task automatic model_reset();
        mv = 1'b0; md = '0; mrd = 0; movr = 1'b0;
        sb.delete();
    endtask

    task automatic step();
        logic          nmv;
        logic [DW-1:0] nmd;
        int            nrd;
        logic          novr;
        int            cnt;
        logic [DW-1:0] e;
        nmv = mv; nmd = md; nrd = mrd; novr = movr;
        cnt = mcount();
        if (reset_n && sb_en && mv && m_ready && !flush) begin
            if (sb.size() == 0) chk("sb_underflow", 32'(1), 32'(0));
            else begin
                e = sb.pop_front();
                chk("sb_order", 32'(m_data), 32'(e));
            end
        end
        if (reset_n) begin
            if (flush) begin
                nmv = 1'b0; nrd = int'(wr_ptr); novr = 1'b0;
                sb.delete();
            end else begin
                if (cnt != 0 && (!mv || m_ready)) begin
                    nmd = mem[mrd % DEPTH]; nmv = 1'b1; nrd = (mrd + 1) & 31;
                end else if (mv && m_ready) begin
                    nmv = 1'b0;
                end
                if (cnt > DEPTH) novr = 1'b1;
            end
        end
        @(posedge clk);
        mv = nmv; md = nmd; mrd = nrd; movr = novr;
        #1;
        check_all();
    endtask

    task automatic push(input logic [DW-1:0] v);
        mem[wr_ptr[AW-1:0]] = v;
        wr_ptr = wr_ptr + 1'b1;
        if (sb_en) sb.push_back(v);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; wr_ptr = '0; flush = 1'b0;
        model_reset();
        #1;
        check_all();
        step();
        reset_n = 1'b1;
    endtask

    int pushed;
    int cyc;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
        reset_n = 1'b1; flush = 1'b0; m_ready = 1'b0; wr_ptr = '0; sb_en = 1'b1;
        model_reset();
        #2;
        do_reset();

        // Single entry, stalled consumer.
        mem[0] = 8'hA5; wr_ptr = 5'd1; sb.push_back(8'hA5);
        step();
        chk("first_valid", 32'(m_valid), 32'(1));
        chk("first_data",  32'(m_data),  32'hA5);
        chk("first_level", 32'(level),   32'(1));
        for (int i = 0; i < 5; i++) step();
        chk("stall_data",  32'(m_data),  32'hA5);
        m_ready = 1'b1;
        step(); step();

        // Four preloaded entries drained back to back.
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("b2b_data", 32'(m_data), 32'(8'h10 + i));
        end
        step();
        chk("b2b_empty_valid", 32'(m_valid), 32'(0));
        chk("b2b_empty_level", 32'(level),   32'(0));

        // Wrap: move both pointers to 31 via flush, then stream 40 entries.
        wr_ptr = 5'd31; flush = 1'b1;
        step();
        flush = 1'b0;
        pushed = 0; cyc = 0;
        while ((pushed < 40 || mv || mcount() != 0) && cyc < 2000) begin
            m_ready = 1'($urandom_range(0, 3) != 0);
            if (pushed < 40 && mcount() < DEPTH && $urandom_range(0, 1) == 1) begin
                push(8'($urandom));
                pushed++;
            end
            step();
            cyc++;
        end
        chk("wrap_timeout", 32'(cyc < 2000), 32'(1));
        chk("wrap_sb_empty", 32'(sb.size()), 32'(0));

        // Random traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            flush   = 1'($urandom_range(0, 31) == 0);
            if (mcount() < DEPTH && $urandom_range(0, 2) != 0) push(8'($urandom));
            step();
        end
        flush = 1'b0;

        // Flush with six entries pending and consumer ready.
        m_ready = 1'b1;
        step(); step(); step();
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'(8'h60 + i));
        step();
        flush = 1'b1; m_ready = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_valid", 32'(m_valid), 32'(0));
        chk("flush_ptr",   32'(rd_ptr),  32'(wr_ptr));
        chk("flush_level", 32'(level),   32'(0));
        step();
        chk("flush_no_xfer", 32'(m_valid), 32'(0));

        // Overrun: write pointer forced 17 ahead of rd_ptr = 0.
        do_reset();
        sb_en = 1'b0; m_ready = 1'b0;
        wr_ptr = 5'd17;
        step();
        chk("ovr_set", 32'(overrun), 32'(1));
        for (int i = 0; i < 4; i++) step();
        chk("ovr_sticky", 32'(overrun), 32'(1));
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("ovr_clear", 32'(overrun), 32'(0));
        step();
        sb_en = 1'b1;

        // Asynchronous reset in the middle of a stream.
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push(8'($urandom));
            step();
        end
        #2;
        reset_n = 1'b0; wr_ptr = '0;
        model_reset();
        #1;
        chk("arst_valid", 32'(m_valid), 32'(0));
        chk("arst_ptr",   32'(rd_ptr),  32'(0));
        chk("arst_data",  32'(m_data),  32'(0));
        check_all();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            if (mcount() < DEPTH && $urandom_range(0, 1) == 1) push(8'($urandom));
            step();
        end
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("final_sb_empty", 32'(sb.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
